// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
//   NOP_INST      : instruction presented when no valid instruction is at the head
//   PC_STEP       : fetch address increment per word
//   fetch_state_e : fetch FSM states (boot, fetch, drain)
//   fetch_entry_t : one fetch-queue entry {pc, inst}
package if_fetch_unit_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StDrain
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Force a fetch address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// In-order fetch queue: synchronous FIFO of {pc, inst} entries.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-low reset
//   clear_i         drop every entry (wins over push/pop)
//   push_i, push_data_i   write one entry at the tail
//   pop_i           consume the head entry
//   head_o          entry at the head (undefined content when empty_o)
//   full_o, empty_o, count_o   occupancy status
module if_fetch_queue
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              push_i,
    input  fetch_entry_t      push_data_i,
    input  logic              pop_i,
    output fetch_entry_t      head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CntW-1:0]   count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Payload storage needs no reset: it is only observed through count_q.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues word requests over a
// request/grant/response handshake, queues returned words in order and
// presents one {pc, inst} per cycle to the IF/ID register.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   stall_i                      IF/ID not accepting this cycle
//   flush_i, redirect_pc_i       discard fetched/in-flight work, restart at redirect_pc_i
//   imem_req_o, imem_addr_o      fetch request and word-aligned address
//   imem_gnt_i                   same-cycle acceptance of the request
//   imem_rvalid_i, imem_rdata_i  in-order response
//   pc_o, inst_o, valid_o        head of the fetch queue (inst_o = NOP when !valid_o)
// Build option IF_PERF_CNT_EN adds perf_fetch_o (queue pushes) and
// perf_stall_o (cycles with valid_o && stall_i), both free-running 32-bit.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o
`endif
);

    localparam int unsigned CntW = $clog2(QDEPTH + 1);
    localparam int unsigned SumW = CntW + 1;

    fetch_state_e    state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [CntW-1:0] outst_q, outst_d;
    logic [CntW-1:0] drop_q, drop_d;

    fetch_entry_t    q_head, q_push_data;
    logic            q_push, q_pop, q_full, q_empty;
    logic [CntW-1:0] q_count;

    logic            pop, grant, resp;
    logic [SumW-1:0] credits_used;

    logic            unused_q_full;
    assign unused_q_full = q_full;

    // ------------------------------------------------------------------
    // Issue / response handshake
    // ------------------------------------------------------------------
    assign valid_o = !q_empty;
    assign pop     = valid_o && !stall_i;

    // A head being consumed this cycle frees its slot before any response
    // granted now can land, so it counts as free; this keeps issue going at
    // one word per cycle with a two-entry queue and one-cycle memory.
    assign credits_used = SumW'(q_count) + SumW'(outst_q) - SumW'(pop);
    assign imem_req_o   = (state_q != StBoot) && (credits_used < SumW'(QDEPTH));
    assign imem_addr_o  = fetch_pc_q;
    assign grant        = imem_req_o && imem_gnt_i;

    // Responses with nothing outstanding (e.g. leftovers after reset) are ignored.
    assign resp = imem_rvalid_i && (outst_q != '0);

    assign q_push      = resp && (drop_q == '0) && !flush_i;
    assign q_pop       = pop && !flush_i;
    assign q_push_data = '{pc: resp_pc_q, inst: imem_rdata_i};

    // Grants in a flush cycle still reach memory, so they stay outstanding
    // and end up in the drop count below.
    assign outst_d = outst_q + CntW'(grant) - CntW'(resp);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q;

        if (grant) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end

        // resp_pc tracks the address of the next response that will be kept;
        // kept responses are always consecutive words of the current path.
        if (resp) begin
            if (drop_q != '0) begin
                drop_d = drop_q - 1'b1;
            end else begin
                resp_pc_d = resp_pc_q + PC_STEP;
            end
        end

        case (state_q)
            StBoot:  state_d = StFetch;
            StFetch: state_d = StFetch;
            StDrain: begin
                if (drop_d == '0) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StBoot;
        endcase

        // Flush overrides every other update this cycle. Everything still in
        // flight afterwards belongs to the old path, including anything
        // dropped earlier but not yet returned.
        if (flush_i) begin
            fetch_pc_d = word_align(redirect_pc_i);
            resp_pc_d  = word_align(redirect_pc_i);
            drop_d     = outst_d;
            state_d    = (outst_d != '0) ? StDrain : StFetch;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StBoot;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Fetch queue and outputs
    // ------------------------------------------------------------------
    if_fetch_queue #(
        .Depth (QDEPTH),
        .CntW  (CntW)
    ) u_queue (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (flush_i),
        .push_i      (q_push),
        .push_data_i (q_push_data),
        .pop_i       (q_pop),
        .head_o      (q_head),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .count_o     (q_count)
    );

    assign pc_o   = q_empty ? 32'h0000_0000 : q_head.pc;
    assign inst_o = q_empty ? NOP_INST : q_head.inst;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_q + 32'(q_push);
            perf_stall_q <= perf_stall_q + 32'(valid_o && stall_i);
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
`timescale 1ns/1ps
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned QDEPTH   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] pc_o, inst_o;
    logic        valid_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_stall;
`endif

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .stall_i       (stall),
        .flush_i       (flush),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .valid_o       (valid_o)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_o  (perf_fetch),
        .perf_stall_o  (perf_stall)
`endif
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned consumed = 0;

    // Program image: every word address holds a distinct, address-derived word.
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event did not occur (t=%0t)", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: the architectural instruction stream is sequential
    // words from the last reset/redirect target.
    // ------------------------------------------------------------------
    fetch_entry_t exp_q[$];
    logic [31:0]  exp_next_pc;

    function automatic void extend_stream(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: exp_next_pc, inst: inst_of(exp_next_pc)});
            exp_next_pc = exp_next_pc + 32'd4;
        end
    endfunction

    function automatic void restart_stream(input logic [31:0] pc);
        exp_q.delete();
        exp_next_pc = {pc[31:2], 2'b00};
        extend_stream(8);
    endfunction

    // ------------------------------------------------------------------
    // Memory model: grants per gnt_pct, in-order responses per rv_pct,
    // at least one cycle after the grant.
    // Drive at negedge+0, sample DUT requests at negedge+2.
    // ------------------------------------------------------------------
    int unsigned gnt_pct = 100;
    int unsigned rv_pct  = 100;
    logic [31:0] pending_q[$];
    logic [31:0] grant_log[$];

    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending_q.delete();
                imem_gnt    = 1'b0;
                imem_rvalid = 1'b0;
            end else begin
                if (pending_q.size() > 0 && $urandom_range(99) < rv_pct) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = inst_of(pending_q.pop_front());
                end else begin
                    imem_rvalid = 1'b0;
                    imem_rdata  = $urandom;
                end
                imem_gnt = ($urandom_range(99) < gnt_pct);
            end
            #2;
            if (rst_n && imem_req && imem_gnt) begin
                pending_q.push_back(imem_addr);
                grant_log.push_back(imem_addr);
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: at negedge+3, every consumed head is popped from the
    // scoreboard and compared.
    // ------------------------------------------------------------------
    logic chk_invalid = 1'b0;

    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
                if (chk_invalid) begin
                    check("valid_after_flush", 32'(valid_o), 32'h0);
                    chk_invalid = 1'b0;
                end
                if (!valid_o) begin
                    check("nop_when_invalid", inst_o, NOP_INST);
                end else if (!stall && !flush) begin
                    if (exp_q.size() == 0) begin
                        fail("scoreboard_empty");
                    end else begin
                        e = exp_q.pop_front();
                        check("head_pc", pc_o, e.pc);
                        check("head_inst", inst_o, e.inst);
                        consumed++;
                        if (exp_q.size() < 4) extend_stream(8);
                    end
                end
                if (flush) chk_invalid = 1'b1;
            end
        end
    end

    // Main stimulus: drive at negedge+1, directed checks at negedge+2.
    task automatic drive_pt();
        @(negedge clk);
        #1;
    endtask

    task automatic check_pt();
        #1;
    endtask

    initial begin
        bit seen;
        rst_n       = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect_pc = 32'h0;

        // Reset values
        repeat (3) @(negedge clk);
        #2;
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_pc", pc_o, 32'h0);
        check("rst_inst", inst_o, NOP_INST);
        check("rst_valid", 32'(valid_o), 32'h0);
        restart_stream(RESET_PC);

        // First fetches: req in cycle 2, first valid in cycle 4
        drive_pt(); rst_n = 1'b1; check_pt();
        check("boot_no_req", 32'(imem_req), 32'h0);
        drive_pt(); check_pt();
        check("c2_req", 32'(imem_req), 32'h1);
        check("c2_addr", imem_addr, 32'h0);
        drive_pt(); check_pt();
        check("c3_addr", imem_addr, 32'h4);
        check("c3_valid", 32'(valid_o), 32'h0);
        drive_pt(); check_pt();
        check("c4_addr", imem_addr, 32'h8);
        check("c4_valid", 32'(valid_o), 32'h1);
        check("c4_pc", pc_o, 32'h0);
        for (int i = 0; i < 10; i++) begin
            drive_pt(); check_pt();
            check("stream_req", 32'(imem_req), 32'h1);
            check("stream_valid", 32'(valid_o), 32'h1);
        end

        // Stall with queue filling: head held, no requests
        for (int i = 0; i < 5; i++) begin
            drive_pt(); stall = 1'b1; check_pt();
            check("stall_req", 32'(imem_req), 32'h0);
            check("stall_head", pc_o, exp_q[0].pc);
            check("stall_addr", imem_addr, exp_q[0].pc + 32'd8);
        end
        drive_pt(); stall = 1'b0; check_pt();
        check("resume_req", 32'(imem_req), 32'h1);
        check("resume_addr", imem_addr, exp_q[0].pc + 32'd8);

        // Drain completely; with no flushes every push has been consumed
        drive_pt(); gnt_pct = 0;
        repeat (8) drive_pt();
        check_pt();
        check("drained_valid", 32'(valid_o), 32'h0);
`ifdef IF_PERF_CNT_EN
        check("perf_fetch", perf_fetch, consumed);
        check("perf_stall", perf_stall, 32'd5);
`endif

        // Two requests in flight, then flush to an unaligned redirect
        drive_pt(); gnt_pct = 100; rv_pct = 0;
        repeat (3) drive_pt();
        check_pt();
        check("credit_stop_req", 32'(imem_req), 32'h0);
        drive_pt(); flush = 1'b1; redirect_pc = 32'h0000_0103; restart_stream(32'h0000_0103);
        drive_pt(); flush = 1'b0; rv_pct = 100; check_pt();
        check("redir_valid", 32'(valid_o), 32'h0);
        check("redir_addr", imem_addr, 32'h0000_0100);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            drive_pt(); check_pt();
            if (valid_o) begin
                seen = 1;
                check("redir_first_pc", pc_o, 32'h0000_0100);
            end
        end
        if (!seen) fail("redir_first_valid_timeout");

        // Flush in the same cycle as a response
        repeat (6) drive_pt();
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            drive_pt();
            if (imem_rvalid) begin
                seen = 1;
                flush = 1'b1;
                redirect_pc = 32'h0000_0200;
                restart_stream(32'h0000_0200);
            end
        end
        if (!seen) fail("rvalid_for_flush_timeout");
        drive_pt(); flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            drive_pt(); check_pt();
            if (valid_o) begin
                seen = 1;
                check("flush_rv_first_pc", pc_o, 32'h0000_0200);
            end
        end
        if (!seen) fail("flush_rv_valid_timeout");

        // Address wrap at the top of memory
        drive_pt(); flush = 1'b1; redirect_pc = 32'hFFFF_FFF8; restart_stream(32'hFFFF_FFF8);
        drive_pt(); flush = 1'b0; grant_log.delete();
        repeat (6) drive_pt();
        if (grant_log.size() < 3) begin
            fail("wrap_grants");
        end else begin
            check("wrap_g0", grant_log[0], 32'hFFFF_FFF8);
            check("wrap_g1", grant_log[1], 32'hFFFF_FFFC);
            check("wrap_g2", grant_log[2], 32'h0000_0000);
        end

        // Randomised traffic
        for (int seg = 0; seg < 10; seg++) begin
            gnt_pct = $urandom_range(100, 30);
            rv_pct  = $urandom_range(100, 30);
            for (int i = 0; i < 200; i++) begin
                drive_pt();
                stall = ($urandom_range(99) < 25);
                flush = ($urandom_range(99) < 3);
                if (flush) begin
                    redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                           : $urandom;
                    restart_stream(redirect_pc);
                end
            end
        end

        drive_pt(); stall = 1'b0; flush = 1'b0;
        repeat (4) drive_pt();
        if (consumed == 0) fail("nothing_consumed");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
